ex_operand_ctrl: RTL and testbench

EX_OPERAND_CTRL -- requirements
Module: ex_operand_ctrl

---
 rtl/ex_operand_ctrl.sv | 135 +++++++++++++
 tb/tb_ex_operand_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ex_operand_ctrl.sv
// EX-stage operand control: forwarding selects, load-use interlock and the
// multiply/divide occupancy sequencer that stalls the front end while it runs.
module ex_operand_ctrl #(
   parameter int MD_CYCLES = 32
) (
   input  logic       Clk,
   input  logic       Reset_L,
   input  logic [4:0] Rs_ID,
   input  logic [4:0] Rt_ID,
   input  logic [4:0] Rs_EX,
   input  logic [4:0] Rt_EX,
   input  logic [4:0] Rd_MEM,
   input  logic [4:0] Rd_WB,
   input  logic       Uses_Rt_ID,
   input  logic       ALUSrc_ID,
   input  logic       MultDiv_Start_ID,
   input  logic       MemRead_EX,
   input  logic       RegWrite_MEM,
   input  logic       RegWrite_WB,
   output logic [1:0] ForwardA_EX,
   output logic [1:0] ForwardB_EX,
   output logic       ALUSrc_EX,
   output logic       Stall_IF_ID,
   output logic       Flush_ID_EX,
   output logic       Hold_EX,
   output logic       MD_Busy,
   output logic       MD_Done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } state_t;

   localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

   state_t     state, state_nxt;
   logic [5:0] cnt, cnt_nxt;
   logic       alu_src_nxt;
   logic       load_use;

   // MEM/WB-stage producer match; the younger (MEM) result wins.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] rd_mem,
                                          input logic       wr_mem,
                                          input logic [4:0] rd_wb,
                                          input logic       wr_wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_mem && (rd_mem != 5'd0) && (rd_mem == src)) begin
         sel = 2'b10;
      end else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign load_use = MemRead_EX && (Rt_EX != 5'd0) &&
                     ((Rt_EX == Rs_ID) || (Uses_Rt_ID && (Rt_EX == Rt_ID)));

   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         state     <= IDLE;
         cnt       <= 6'd0;
         ALUSrc_EX <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ALUSrc_EX <= alu_src_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      alu_src_nxt = ALUSrc_EX;
      ForwardA_EX = fwd_sel(Rs_EX, Rd_MEM, RegWrite_MEM, Rd_WB, RegWrite_WB);
      ForwardB_EX = fwd_sel(Rt_EX, Rd_MEM, RegWrite_MEM, Rd_WB, RegWrite_WB);
      Stall_IF_ID = 1'b0;
      Flush_ID_EX = 1'b0;
      Hold_EX     = 1'b0;
      MD_Busy     = 1'b0;
      MD_Done     = 1'b0;

      case (state)
         IDLE: begin
            if (load_use) begin
               // Bubble into EX: the flushed slot must not select the immediate.
               Stall_IF_ID = 1'b1;
               Flush_ID_EX = 1'b1;
               alu_src_nxt = 1'b0;
            end else if (MultDiv_Start_ID) begin
               alu_src_nxt = ALUSrc_ID;
               cnt_nxt     = MD_LOAD;
               state_nxt   = MD_RUN;
            end else begin
               alu_src_nxt = ALUSrc_ID;
            end
         end
         MD_RUN: begin
            Stall_IF_ID = 1'b1;
            Hold_EX     = 1'b1;
            MD_Busy     = 1'b1;
            // A zero count here is unreachable in normal use; bail out rather than wrap.
            if (cnt <= 6'd1) begin
               state_nxt = MD_DONE;
            end
            if (cnt != 6'd0) begin
               cnt_nxt = cnt - 6'd1;
            end
         end
         MD_DONE: begin
            Stall_IF_ID = 1'b1;
            MD_Busy     = 1'b1;
            MD_Done     = 1'b1;
            state_nxt   = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (!Reset_L) begin
         ForwardA_EX = 2'b00;
         ForwardB_EX = 2'b00;
         Stall_IF_ID = 1'b0;
         Flush_ID_EX = 1'b0;
         Hold_EX     = 1'b0;
         MD_Busy     = 1'b0;
         MD_Done     = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Directed bench for ex_operand_ctrl: stimulus pushes hand-computed expected
// output vectors, a negedge monitor pops and compares them.
module tb_ex_operand_ctrl;

   logic       Clk;
   logic       Reset_L;
   logic [4:0] Rs_ID, Rt_ID, Rs_EX, Rt_EX, Rd_MEM, Rd_WB;
   logic       Uses_Rt_ID, ALUSrc_ID, MultDiv_Start_ID, MemRead_EX;
   logic       RegWrite_MEM, RegWrite_WB;
   logic [1:0] ForwardA_EX, ForwardB_EX;
   logic       ALUSrc_EX, Stall_IF_ID, Flush_ID_EX, Hold_EX, MD_Busy, MD_Done;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];
   string      name_q[$];

   ex_operand_ctrl #(.MD_CYCLES(4)) dut (
      .Clk(Clk), .Reset_L(Reset_L),
      .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
      .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
      .Uses_Rt_ID(Uses_Rt_ID), .ALUSrc_ID(ALUSrc_ID),
      .MultDiv_Start_ID(MultDiv_Start_ID), .MemRead_EX(MemRead_EX),
      .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
      .ForwardA_EX(ForwardA_EX), .ForwardB_EX(ForwardB_EX),
      .ALUSrc_EX(ALUSrc_EX), .Stall_IF_ID(Stall_IF_ID),
      .Flush_ID_EX(Flush_ID_EX), .Hold_EX(Hold_EX),
      .MD_Busy(MD_Busy), .MD_Done(MD_Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Vector layout: {fwdA, fwdB, alusrc_ex, stall, flush, hold, busy, done}
   function automatic logic [9:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic alu, input logic st,
                                     input logic fl, input logic ho,
                                     input logic bu, input logic dn);
      return {fa, fb, alu, st, fl, ho, bu, dn};
   endfunction

   task automatic cyc();
      @(posedge Clk);
      #1;
      Reset_L          = 1'b1;
      Rs_ID            = 5'd0;
      Rt_ID            = 5'd0;
      Rs_EX            = 5'd0;
      Rt_EX            = 5'd0;
      Rd_MEM           = 5'd0;
      Rd_WB            = 5'd0;
      Uses_Rt_ID       = 1'b0;
      ALUSrc_ID        = 1'b0;
      MultDiv_Start_ID = 1'b0;
      MemRead_EX       = 1'b0;
      RegWrite_MEM     = 1'b0;
      RegWrite_WB      = 1'b0;
   endtask

   task automatic push(input string n, input logic [9:0] e);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   always @(negedge Clk) begin
      logic [9:0] act, e;
      string      n;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         n   = name_q.pop_front();
         act = {ForwardA_EX, ForwardB_EX, ALUSrc_EX, Stall_IF_ID, Flush_ID_EX,
                Hold_EX, MD_Busy, MD_Done};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b required %b (fa fb alu st fl ho bu dn)", n, act, e);
         end
      end
   end

   initial begin
      cyc(); Reset_L = 1'b0;
      cyc(); Reset_L = 1'b0;
      RegWrite_MEM = 1; Rd_MEM = 8; Rs_EX = 8; MemRead_EX = 1; Rt_EX = 9; Rs_ID = 9;
      push("reset_gating", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      cyc();
      push("idle_after_reset", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));

      // Forwarding priority
      cyc(); RegWrite_MEM = 1; Rd_MEM = 8; RegWrite_WB = 1; Rd_WB = 8; Rs_EX = 8; Rt_EX = 8;
      push("fwd_mem_prio", mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
      cyc(); RegWrite_MEM = 1; Rd_MEM = 0; RegWrite_WB = 1; Rd_WB = 8; Rs_EX = 8; Rt_EX = 8;
      push("fwd_wb_rd_mem0", mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
      cyc(); RegWrite_MEM = 1; Rd_MEM = 0; RegWrite_WB = 0; Rd_WB = 8; Rs_EX = 8; Rt_EX = 8;
      push("fwd_none", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      cyc(); RegWrite_MEM = 1; Rd_MEM = 4; Rs_EX = 4; RegWrite_WB = 1; Rd_WB = 7; Rt_EX = 7;
      ALUSrc_ID = 1;
      push("fwd_mixed", mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0));
      cyc(); RegWrite_WB = 1;
      push("fwd_r0_alusrc_load", mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0));

      // Load-use
      cyc(); ALUSrc_ID = 1; MemRead_EX = 1; Rt_EX = 9; Rs_ID = 9;
      push("lu_rs_stall", mk(2'b00, 2'b00, 0, 1, 1, 0, 0, 0));
      cyc(); ALUSrc_ID = 1; MemRead_EX = 1;
      push("lu_bubble_rt0", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      cyc();
      push("after_bubble", mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
      cyc(); MemRead_EX = 1; Rt_EX = 5; Rs_ID = 3; Rt_ID = 5; Uses_Rt_ID = 0;
      push("lu_rt_unused", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      cyc(); MemRead_EX = 1; Rt_EX = 5; Rs_ID = 3; Rt_ID = 5; Uses_Rt_ID = 1;
      push("lu_rt_used", mk(2'b00, 2'b00, 0, 1, 1, 0, 0, 0));

      // Load-use beats multiply start
      cyc(); MemRead_EX = 1; Rt_EX = 9; Rs_ID = 9; MultDiv_Start_ID = 1; ALUSrc_ID = 1;
      push("prio_lu_over_md", mk(2'b00, 2'b00, 0, 1, 1, 0, 0, 0));
      cyc();
      push("prio_stays_idle", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));

      // Multi-cycle sequence, MD_CYCLES=4
      cyc(); MultDiv_Start_ID = 1; ALUSrc_ID = 1;
      push("md_start", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      cyc();
      push("md_run1", mk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0));
      cyc(); MemRead_EX = 1; Rt_EX = 9; Rs_ID = 9; MultDiv_Start_ID = 1;
      push("md_run2_ignore", mk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0));
      cyc();
      push("md_run3", mk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0));
      cyc();
      push("md_done", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1));
      cyc();
      push("md_idle", mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
      cyc();
      push("md_no_restart", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));

      // Reset abort during second MD_RUN cycle
      cyc(); MultDiv_Start_ID = 1; ALUSrc_ID = 1;
      push("abort_start", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      cyc();
      push("abort_run1", mk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0));
      cyc(); Reset_L = 0; RegWrite_MEM = 1; Rd_MEM = 8; Rs_EX = 8;
      push("abort_reset_cycle", mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         cyc();
         push($sformatf("abort_quiet%0d", i), mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
      end

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge Clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d vectors left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
